// File: rtl/video_pkg.sv
// Shared video definitions: default geometry, greyscale width, BT.601-style
// luma coefficients scaled by 256, and the packed RGB888 pixel type.
package video_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    // Luma weights, sum = 256, so (sum of products + 128) >> 8 rounds to nearest
    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

endpackage

// File: rtl/rgb_to_grey_stream_if.sv
// Stream bundle for rgb_to_grey_stream: RGB input with valid/ready, greyscale
// output with valid/ready plus frame markers, and the beat pulse.
// slave = the converter's view, master = the surrounding pipeline's view.
interface rgb_to_grey_stream_if
    import video_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    rgb888_t                 pixel_in;
    logic                    pixel_in_valid;
    logic                    output_ready;
    logic                    module_ready;
    logic [DATA_WIDTH-1:0]   pixel_out;
    logic                    pixel_out_valid;
    logic                    start_of_frame;
    logic                    end_of_line;
    logic                    beat_detected;

    modport slave (
        input  pixel_in,
        input  pixel_in_valid,
        input  module_ready,
        input  beat_detected,
        output output_ready,
        output pixel_out,
        output pixel_out_valid,
        output start_of_frame,
        output end_of_line
    );

    modport master (
        output pixel_in,
        output pixel_in_valid,
        output module_ready,
        output beat_detected,
        input  output_ready,
        input  pixel_out,
        input  pixel_out_valid,
        input  start_of_frame,
        input  end_of_line
    );

endinterface

// File: rtl/rgb_to_grey_stream_frame_position_counter.sv
// Tracks the x/y position of the pixel currently on the output and derives
// start_of_frame / end_of_line for it. Position advances only on a transfer.
module frame_position_counter
    import video_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
)(
    input  logic clk,
    input  logic reset,
    input  logic i_xfer,
    input  logic i_valid,
    output logic o_sof,
    output logic o_eol,
    output logic o_frame_done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    // Raster position of the pixel on the output; steps once per transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_xfer) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign o_sof        = i_valid && (r_x == '0) && (r_y == '0);
    assign o_eol        = i_valid && w_x_last;
    assign o_frame_done = i_xfer && w_x_last && w_y_last;

endmodule

// File: rtl/rgb_to_grey_stream.sv
// RGB888 -> greyscale stream converter, two-stage valid/ready pipeline.
// Stage 1 registers the three weighted products, stage 2 the rounded sum.
// Optional feature macro: BEAT_FLASH_EN (brightens FLASH_FRAMES frames after
// each beat_detected pulse; saturating add sits in stage 2).
module rgb_to_grey_stream
    import video_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
    parameter int FLASH_FRAMES = 4,
    parameter int FLASH_GAIN   = 64
)(
    input  logic              clk,
    input  logic              reset,
    rgb_to_grey_stream_if.slave bus
);

    // Rounded luma from the registered products; cannot overflow 16 bits
    // (255 * 256 + 128 = 65408).
    function automatic logic [7:0] luma_round(input logic [15:0] pr,
                                              input logic [15:0] pg,
                                              input logic [15:0] pb);
        logic [15:0] s;
        s = pr + pg + pb + 16'd128;
        return 8'(s >> 8);
    endfunction

    logic        r_vld_p1;
    logic [15:0] r_prod_r_p1;
    logic [15:0] r_prod_g_p1;
    logic [15:0] r_prod_b_p1;
    logic        r_vld_p2;
    logic [DATA_WIDTH-1:0] r_grey_p2;

    logic        w_s2_ready;
    logic        w_out_ready;
    logic        w_xfer;
    logic        w_frame_done;
    logic [7:0]  w_grey;
    logic [7:0]  w_grey_adj;

    // Stage 2 can take stage 1's content when it is empty or being drained
    assign w_s2_ready  = !r_vld_p2 || bus.module_ready;
    assign w_out_ready = !r_vld_p1 || w_s2_ready;
    assign w_xfer      = r_vld_p2 && bus.module_ready;
    assign w_grey      = luma_round(r_prod_r_p1, r_prod_g_p1, r_prod_b_p1);

`ifdef BEAT_FLASH_EN
    localparam int FCW = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

    function automatic logic [7:0] sat_add_gain(input logic [7:0] g);
        logic [8:0] s;
        s = {1'b0, g} + 9'(FLASH_GAIN);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [FCW-1:0] r_flash_cnt;
    logic [FCW-1:0] w_flash_next;

    // Beat reloads the frame countdown; each completed frame consumes one
    always_comb begin
        w_flash_next = r_flash_cnt;
        if (bus.beat_detected) begin
            w_flash_next = FCW'(FLASH_FRAMES);
        end else if (w_frame_done && (r_flash_cnt != '0)) begin
            w_flash_next = r_flash_cnt - FCW'(1);
        end
    end

    // Flash frame countdown register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flash_cnt <= '0;
        end else begin
            r_flash_cnt <= w_flash_next;
        end
    end

    // Use the post-update count so a pixel entering stage 2 on the edge that
    // ends a frame is judged by the frame it belongs to.
    assign w_grey_adj = (w_flash_next != '0) ? sat_add_gain(w_grey) : w_grey;
`else
    localparam int unused_flash_cfg = FLASH_FRAMES + FLASH_GAIN;
    logic w_unused_ctl;
    assign w_unused_ctl = bus.beat_detected | w_frame_done;
    assign w_grey_adj   = w_grey;
`endif

    // ---- stage 1: accept pixel, register weighted products ----
    // Stage 1 occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1 <= 1'b0;
        end else if (w_out_ready) begin
            r_vld_p1 <= bus.pixel_in_valid;
        end
    end

    // Stage 1 products, loaded only on an accept
    always_ff @(posedge clk) begin
        if (w_out_ready && bus.pixel_in_valid) begin
            r_prod_r_p1 <= 16'(COEF_R) * 16'(bus.pixel_in.r);
            r_prod_g_p1 <= 16'(COEF_G) * 16'(bus.pixel_in.g);
            r_prod_b_p1 <= 16'(COEF_B) * 16'(bus.pixel_in.b);
        end
    end

    // ---- stage 2: rounded sum (and flash gain) onto the output ----
    // Output register, held while the downstream stage stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p2  <= 1'b0;
            r_grey_p2 <= '0;
        end else if (w_s2_ready) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_grey_p2 <= DATA_WIDTH'(w_grey_adj);
            end
        end
    end

    frame_position_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_pos (
        .clk          (clk),
        .reset        (reset),
        .i_xfer       (w_xfer),
        .i_valid      (r_vld_p2),
        .o_sof        (bus.start_of_frame),
        .o_eol        (bus.end_of_line),
        .o_frame_done (w_frame_done)
    );

    assign bus.output_ready    = w_out_ready;
    assign bus.pixel_out       = r_grey_p2;
    assign bus.pixel_out_valid = r_vld_p2;

endmodule

// File: doc/rgb_to_grey_stream.md
RGB_TO_GREY_STREAM -- requirements
Module: rgb_to_grey_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, greyscale output pixel width.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-004 SHALL have parameter FLASH_FRAMES, default 4, frames brightened per beat.
REQ-005 SHALL have parameter FLASH_GAIN, default 64, additive brightness during flash.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port pixel_in  in  24  RGB888 pixel, R[23:16] G[15:8] B[7:0].
REQ-009 SHALL have port pixel_in_valid  in  1  pixel_in valid.
REQ-010 SHALL have port output_ready  out  1  block can accept pixel_in this cycle.
REQ-011 SHALL have port module_ready  in  1  downstream blur stage accepts pixel_out.
REQ-012 SHALL have port pixel_out  out  DATA_WIDTH  greyscale pixel.
REQ-013 SHALL have port pixel_out_valid  out  1  pixel_out valid.
REQ-014 SHALL have port start_of_frame  out  1  high with the pixel at x=0, y=0.
REQ-015 SHALL have port end_of_line  out  1  high with the pixel at x=IMG_WIDTH-1.
REQ-016 SHALL have port beat_detected  in  1  single-cycle beat pulse.

Function
REQ-017 SHALL accept a pixel when pixel_in_valid && output_ready.
REQ-018 SHALL compute grey = (77*R + 150*G + 29*B + 128) >> 8 in 16-bit unsigned arithmetic, with no overflow possible.
REQ-019 SHALL use a 2-stage pipeline: stage 1 registers the three products, stage 2 registers the sum and shift; latency is 2 cycles with module_ready held high.
REQ-020 SHALL advance a stage only when the next stage is empty or is being drained; output_ready = !stage1_full || stage2 advancing (combinational).
REQ-021 SHALL hold pixel_out, pixel_out_valid, start_of_frame and end_of_line stable while pixel_out_valid && !module_ready.
REQ-022 SHALL sustain 1 pixel/cycle with module_ready high, with no bubbles inserted.
REQ-023 SHALL count x/y on each output transfer (pixel_out_valid && module_ready); x wraps IMG_WIDTH-1 -> 0 and increments y; y wraps IMG_HEIGHT-1 -> 0.
REQ-024 SHALL drive start_of_frame and end_of_line from the counter value of the pixel currently on pixel_out, qualified by pixel_out_valid.

Reset
REQ-025 SHALL, while reset=0, drive pixel_out=0, pixel_out_valid=0, start_of_frame=0, end_of_line=0, empty both stages, and set x=y=0 and the flash counter to 0.
REQ-026 SHALL drive output_ready=1 in the first cycle after reset deasserts.
REQ-027 SHALL discard in-flight pixels when reset asserts mid-frame; the first pixel after release is x=0, y=0.

Configuration
REQ-028 SHALL, with BEAT_FLASH_EN defined, load the flash counter with FLASH_FRAMES on beat_detected; a beat during a flash reloads it.
REQ-029 SHALL, with BEAT_FLASH_EN defined, decrement a nonzero flash counter at each transfer where x=IMG_WIDTH-1, y=IMG_HEIGHT-1.
REQ-030 SHALL, with BEAT_FLASH_EN defined and the counter nonzero, output min(grey + FLASH_GAIN, 255); the saturating add lives in stage 2, so latency is unchanged.
REQ-031 SHALL, without BEAT_FLASH_EN, ignore beat_detected, omit the counter, and keep the port present.

Structure
REQ-032 SHALL take DATA_WIDTH defaults, IMG_WIDTH/IMG_HEIGHT defaults, the luma coefficients (77/150/29) and the rgb888_t packed struct from shared package video_pkg.
REQ-033 SHALL implement the x/y counters and the start_of_frame/end_of_line flags in sub-module frame_position_counter.

Verification
REQ-034 SHALL cover: inputs FFFFFF, FF0000, 00FF00, 0000FF, back-to-back, module_ready=1 -> outputs 255, 77, 149, 29 on cycles 2-5 after the first accept.
REQ-035 SHALL cover: module_ready=0 for 5 cycles with the pipe full -> output_ready=0 after 2 accepts, pixel_out held, and no pixel lost or duplicated on release.
REQ-036 SHALL cover: streaming 640x480 pixels -> start_of_frame on transfer 1 and 307201, end_of_line on every 640th transfer.
REQ-037 SHALL cover: BEAT_FLASH_EN with a beat, then FF0000 and FFFFFF -> 141 and 255 (saturated) for 4 frames, then 77 and 255.
REQ-038 SHALL cover: reset=0 mid-line at x=300 -> all outputs 0 asynchronously, and the next output is flagged start_of_frame.
